// File: rtl/logs_voice_alloc.sv
// logs_voice_alloc: assigns note-on/note-off requests to N voice slots and
// drives the mixer mask plus per-voice tag and oscillator reload strobes.
// Each request scans the slots one per cycle, then commits in a single cycle.
// Optional build macro: LOGS_VALLOC_RELEASE_EN adds a per-voice release hold
// of REL_CYC cycles after note-off before a slot becomes free.
module logs_voice_alloc #(
  parameter int N       = 4,
  parameter int TAG_W   = 7,
  parameter int REL_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_on,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               panic,
  output logic [N-1:0]       voice_mask,
  output logic [N*TAG_W-1:0] voice_tag,
  output logic [N-1:0]       voice_load
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int AGE_W = IDX_W;
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  // Elaboration-time sanity check on the configuration
  if (N < 1 || TAG_W < 1 || REL_CYC < 0) begin : g_bad_cfg
    $error("logs_voice_alloc: invalid parameter set");
  end

  // Request and scan bookkeeping
  state_t           state_q;
  logic             on_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] k_q;
  logic [N-1:0]     hit_q;
  logic [N-1:0]     free_q;
  logic             old_vld_q;
  logic [IDX_W-1:0] old_idx_q;
  logic [AGE_W-1:0] old_age_q;
`ifdef LOGS_VALLOC_RELEASE_EN
  localparam int CNT_W = (REL_CYC > 0) ? $clog2(REL_CYC + 1) : 1;
  logic             rold_vld_q;
  logic [IDX_W-1:0] rold_idx_q;
  logic [AGE_W-1:0] rold_age_q;
`endif

  // Flattened views of the per-voice state
  logic [N-1:0]     mask_v;
  logic [N-1:0]     load_v;
  logic [N-1:0]     rel_v;
  logic [TAG_W-1:0] tag_v [N];
  logic [AGE_W-1:0] age_v [N];

  // Slot currently under examination
  logic             cur_sound;
  logic             cur_act;
  logic             cur_match;
  logic [AGE_W-1:0] cur_age;
  assign cur_sound = mask_v[k_q];
  assign cur_act   = cur_sound & ~rel_v[k_q];
  assign cur_match = cur_sound & (tag_v[k_q] == tag_q);
  assign cur_age   = age_v[k_q];

  assign req_ready  = (state_q == IDLE) && !panic;
  assign voice_mask = mask_v;
  assign voice_load = load_v;

  // Commit decision: retrigger a match, else lowest free slot, else steal the oldest
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    sel_idx  = old_idx_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_q[i])  hit_idx  = IDX_W'(i);
      if (free_q[i]) free_idx = IDX_W'(i);
    end
    if (|hit_q)               sel_idx = hit_idx;
    else if (|free_q)         sel_idx = free_idx;
`ifdef LOGS_VALLOC_RELEASE_EN
    else if (rold_vld_q)      sel_idx = rold_idx_q;
`endif
    else                      sel_idx = old_idx_q;
  end

  // Request FSM: latch request, scan one slot per cycle, commit, return to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      on_q      <= 1'b0;
      tag_q     <= '0;
      k_q       <= '0;
      hit_q     <= '0;
      free_q    <= '0;
      old_vld_q <= 1'b0;
      old_idx_q <= '0;
      old_age_q <= '0;
`ifdef LOGS_VALLOC_RELEASE_EN
      rold_vld_q <= 1'b0;
      rold_idx_q <= '0;
      rold_age_q <= '0;
`endif
    end else if (panic) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            on_q      <= req_on;
            tag_q     <= req_tag;
            k_q       <= '0;
            hit_q     <= '0;
            free_q    <= '0;
            old_vld_q <= 1'b0;
`ifdef LOGS_VALLOC_RELEASE_EN
            rold_vld_q <= 1'b0;
`endif
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          hit_q[k_q]  <= cur_match;
          free_q[k_q] <= ~cur_sound;
          if (cur_act && (!old_vld_q || cur_age > old_age_q)) begin
            old_vld_q <= 1'b1;
            old_idx_q <= k_q;
            old_age_q <= cur_age;
          end
`ifdef LOGS_VALLOC_RELEASE_EN
          if (rel_v[k_q] && (!rold_vld_q || cur_age > rold_age_q)) begin
            rold_vld_q <= 1'b1;
            rold_idx_q <= k_q;
            rold_age_q <= cur_age;
          end
`endif
          if (k_q == IDX_LAST) state_q <= COMMIT;
          else                 k_q     <= k_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_voice
      logic             slot_mask_q;
      logic [TAG_W-1:0] slot_tag_q;
      logic [AGE_W-1:0] slot_age_q;
      logic             slot_load_q;
      logic             is_sel;
      assign is_sel = (sel_idx == IDX_W'(gi));
`ifdef LOGS_VALLOC_RELEASE_EN
      logic             slot_rel_q;
      logic [CNT_W-1:0] slot_cnt_q;
      assign rel_v[gi] = slot_rel_q;
`else
      assign rel_v[gi] = 1'b0;
`endif

      // Per-voice state: panic and commit updates, release countdown when built
      always_ff @(posedge clk) begin
        if (reset) begin
          slot_mask_q <= 1'b0;
          slot_tag_q  <= '0;
          slot_age_q  <= '0;
          slot_load_q <= 1'b0;
`ifdef LOGS_VALLOC_RELEASE_EN
          slot_rel_q  <= 1'b0;
          slot_cnt_q  <= '0;
`endif
        end else if (panic) begin
          slot_mask_q <= 1'b0;
          slot_age_q  <= '0;
          slot_load_q <= 1'b0;
`ifdef LOGS_VALLOC_RELEASE_EN
          slot_rel_q  <= 1'b0;
          slot_cnt_q  <= '0;
`endif
        end else begin
          slot_load_q <= 1'b0;
`ifdef LOGS_VALLOC_RELEASE_EN
          if (slot_rel_q) begin
            if (slot_cnt_q <= CNT_W'(1)) begin
              slot_mask_q <= 1'b0;
              slot_rel_q  <= 1'b0;
              slot_cnt_q  <= '0;
            end else begin
              slot_cnt_q <= slot_cnt_q - 1'b1;
            end
          end
`endif
          if (state_q == COMMIT) begin
            if (on_q) begin
              if (is_sel) begin
                // Later assignments here override a same-edge expiry
                slot_tag_q  <= tag_q;
                slot_mask_q <= 1'b1;
                slot_age_q  <= '0;
                slot_load_q <= 1'b1;
`ifdef LOGS_VALLOC_RELEASE_EN
                slot_rel_q  <= 1'b0;
                slot_cnt_q  <= '0;
`endif
              end else if (slot_mask_q && slot_age_q != AGE_MAX) begin
                slot_age_q <= slot_age_q + 1'b1;
              end
            end else begin
`ifdef LOGS_VALLOC_RELEASE_EN
              if (hit_q[gi] && slot_mask_q && !slot_rel_q) begin
                slot_rel_q <= 1'b1;
                slot_cnt_q <= CNT_W'(REL_CYC);
              end
`else
              if (hit_q[gi]) slot_mask_q <= 1'b0;
`endif
            end
          end
        end
      end

      assign mask_v[gi] = slot_mask_q;
      assign load_v[gi] = slot_load_q;
      assign tag_v[gi]  = slot_tag_q;
      assign age_v[gi]  = slot_age_q;
      assign voice_tag[gi*TAG_W +: TAG_W] = slot_tag_q;
    end
  endgenerate

endmodule
